// File: rtl/maze_solve.sv
// maze_solve: wall-following maze solver sequencer.
// Alternates forward moves and heading changes with the navigate block.
// At each decision point it picks a new heading from the IR opening
// sensors and the wall affinity latched at solve start. It stops when
// the magnet (maze exit) is detected.
module maze_solve (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_md,
    input  logic        cmd0,
    input  logic        lft_opn,
    input  logic        rght_opn,
    input  logic        mv_cmplt,
    input  logic        sol_cmplt,
    output logic        strt_hdng,
    output logic        strt_mv,
    output logic        stp_lft,
    output logic        stp_rght,
    output logic [11:0] dsrd_hdng
);

    typedef enum logic [2:0] {
        IDLE, MOVE, WAIT_MV, DECIDE, HDNG, WAIT_HDNG, DONE
    } state_t;

    localparam logic [11:0] HDG_N = 12'h000;
    localparam logic [11:0] HDG_W = 12'h3FF;
    localparam logic [11:0] HDG_S = 12'h7FF;
    localparam logic [11:0] HDG_E = 12'hC00;

    // Heading tables. Any value that is not a cardinal heading maps to N.
    function automatic logic [11:0] turn_left(input logic [11:0] h);
        case (h)
            HDG_N:   turn_left = HDG_W;
            HDG_W:   turn_left = HDG_S;
            HDG_S:   turn_left = HDG_E;
            HDG_E:   turn_left = HDG_N;
            default: turn_left = HDG_N;
        endcase
    endfunction

    function automatic logic [11:0] turn_right(input logic [11:0] h);
        case (h)
            HDG_N:   turn_right = HDG_E;
            HDG_E:   turn_right = HDG_S;
            HDG_S:   turn_right = HDG_W;
            HDG_W:   turn_right = HDG_N;
            default: turn_right = HDG_N;
        endcase
    endfunction

    function automatic logic [11:0] turn_rev(input logic [11:0] h);
        case (h)
            HDG_N:   turn_rev = HDG_S;
            HDG_S:   turn_rev = HDG_N;
            HDG_E:   turn_rev = HDG_W;
            HDG_W:   turn_rev = HDG_E;
            default: turn_rev = HDG_N;
        endcase
    endfunction

    state_t      state, nxt_state;
    logic        aff, aff_nxt;
    logic        active_nxt;
    logic [11:0] new_hdng;

    // Next-state logic, affinity capture and the wall-follower heading choice.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        nxt_state = state;
        aff_nxt   = aff;

        if (aff) begin
            if (lft_opn)       new_hdng = turn_left(dsrd_hdng);
            else if (rght_opn) new_hdng = turn_right(dsrd_hdng);
            else               new_hdng = turn_rev(dsrd_hdng);
        end else begin
            if (rght_opn)      new_hdng = turn_right(dsrd_hdng);
            else if (lft_opn)  new_hdng = turn_left(dsrd_hdng);
            else               new_hdng = turn_rev(dsrd_hdng);
        end

        if (!cmd_md) begin
            nxt_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    nxt_state = MOVE;
                    aff_nxt   = cmd0;
                end
                MOVE:    nxt_state = WAIT_MV;
                // A completion in the same cycle as our own start pulse is
                // stale, so it is ignored.
                WAIT_MV:
                    if (mv_cmplt && !strt_mv)
                        nxt_state = sol_cmplt ? DONE : DECIDE;
                DECIDE:  nxt_state = HDNG;
                HDNG:    nxt_state = WAIT_HDNG;
                WAIT_HDNG:
                    if (mv_cmplt && !strt_hdng)
                        nxt_state = sol_cmplt ? DONE : MOVE;
                DONE:    nxt_state = DONE;
                default: nxt_state = IDLE;
            endcase
        end

        active_nxt = (nxt_state != IDLE) && (nxt_state != DONE);
    end

    // State and registered outputs. Start pulses fire on the cycle after
    // MOVE/HDNG. By that time the heading register already holds the value
    // chosen in DECIDE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            aff       <= 1'b0;
            dsrd_hdng <= HDG_N;
            strt_hdng <= 1'b0;
            strt_mv   <= 1'b0;
            stp_lft   <= 1'b0;
            stp_rght  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= nxt_state;
            aff       <= aff_nxt;
            strt_mv   <= cmd_md && (state == MOVE);
            strt_hdng <= cmd_md && (state == HDNG);
            if (cmd_md && (state == DECIDE))
                dsrd_hdng <= new_hdng;
            stp_lft   <= active_nxt & aff_nxt;
            stp_rght  <= active_nxt & ~aff_nxt;
        end
    end

endmodule

// File: tb/tb_maze_solve.sv
// tb_maze_solve: directed bench for maze_solve with hand-computed expectations.
module tb_maze_solve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_md, cmd0, lft_opn, rght_opn, mv_cmplt, sol_cmplt;
    logic        strt_hdng, strt_mv, stp_lft, stp_rght;
    logic [11:0] dsrd_hdng;

    int vectors = 0;
    int miscompares = 0;
    int cnt_mv = 0;
    int cnt_hd = 0;

    maze_solve dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_md    (cmd_md),
        .cmd0      (cmd0),
        .lft_opn   (lft_opn),
        .rght_opn  (rght_opn),
        .mv_cmplt  (mv_cmplt),
        .sol_cmplt (sol_cmplt),
        .strt_hdng (strt_hdng),
        .strt_mv   (strt_mv),
        .stp_lft   (stp_lft),
        .stp_rght  (stp_rght),
        .dsrd_hdng (dsrd_hdng)
    );

    always #10 clk = ~clk;

    // Packed view of all outputs: {strt_mv, strt_hdng, stp_lft, stp_rght, dsrd_hdng}.
    function automatic logic [15:0] outs();
        return {strt_mv, strt_hdng, stp_lft, stp_rght, dsrd_hdng};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 ns after the edge, tallying start pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        cnt_mv += int'(strt_mv);
        cnt_hd += int'(strt_hdng);
    endtask

    task automatic pulse_mv();
        mv_cmplt = 1'b1;
        tick();
        mv_cmplt = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd_md = 1'b0; cmd0 = 1'b0; lft_opn = 1'b0;
        rght_opn = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
        #25;
        check("reset_outs", 32'(outs()), 32'h0000);

        // Start a left-wall solve.
        rst_n = 1'b1;
        tick();
        cmd_md = 1'b1; cmd0 = 1'b1;
        cnt_mv = 0; cnt_hd = 0;
        tick();                                   // MOVE
        check("start_move_state", 32'(outs()), 32'h2000);  // stp_lft only
        tick();                                   // WAIT_MV, strt_mv pulse
        check("strt_mv_pulse", 32'(outs()), 32'hA000);
        mv_cmplt = 1'b1;                          // same cycle as strt_mv: ignored
        tick();
        mv_cmplt = 1'b0;
        repeat (4) tick();
        check("one_strt_mv", 32'(cnt_mv), 32'd1);
        check("mv_cmplt_ignored", 32'(cnt_hd), 32'd0);

        // aff=1, heading N, both openings -> left turn to W.
        lft_opn = 1'b1; rght_opn = 1'b1;
        cnt_mv = 0; cnt_hd = 0;
        pulse_mv();                               // edge k -> DECIDE
        check("decide_no_pulse", 32'(outs()), 32'h2000);
        tick();                                   // HDNG, heading registered
        check("hdng_left_W", 32'(outs()), 32'h23FF);
        tick();                                   // strt_hdng pulse
        check("strt_hdng_pulse", 32'(outs()), 32'h63FF);
        tick();
        pulse_mv();                               // -> MOVE
        tick();                                   // strt_mv
        check("move_after_turn", 32'(outs()), 32'hA3FF);
        repeat (3) tick();
        check("turn_mv_count", 32'(cnt_mv), 32'd1);
        check("turn_hd_count", 32'(cnt_hd), 32'd1);

        // Async reset while in WAIT_MV.
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_wait_mv", 32'(outs()), 32'h0000);
        cmd_md = 1'b0; cmd0 = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        pulse_mv();                               // spurious in IDLE
        tick();
        check("idle_after_reset", 32'(outs()), 32'h0000);

        // aff=0 solve: right turn N->E, then reversal E->W.
        cmd_md = 1'b1;
        tick(); tick(); tick();
        check("right_follower_stp", 32'(outs()), 32'h1000);
        lft_opn = 1'b0; rght_opn = 1'b1;
        pulse_mv(); tick(); tick();
        check("hdng_right_E", 32'(outs()), 32'h5C00);
        tick();
        pulse_mv(); tick(); tick();
        lft_opn = 1'b0; rght_opn = 1'b0;
        pulse_mv(); tick(); tick();
        check("hdng_reverse_W", 32'(outs()), 32'h53FF);

        // Abort in WAIT_HDNG, then a late mv_cmplt.
        tick();
        cmd_md = 1'b0;
        tick();
        pulse_mv();
        cnt_mv = 0; cnt_hd = 0;
        repeat (5) tick();
        check("abort_no_mv", 32'(cnt_mv), 32'd0);
        check("abort_no_hd", 32'(cnt_hd), 32'd0);
        check("abort_outs", 32'(outs()), 32'h03FF);

        // Exit detected with mv_cmplt in WAIT_MV -> DONE.
        cmd_md = 1'b1; cmd0 = 1'b1; lft_opn = 1'b1; rght_opn = 1'b1;
        tick(); tick(); tick();
        sol_cmplt = 1'b1;
        pulse_mv();
        check("done_outs", 32'(outs()), 32'h03FF);
        cnt_mv = 0; cnt_hd = 0;
        for (int i = 0; i < 100; i++) begin
            mv_cmplt = (i == 50);                 // spurious in DONE
            tick();
        end
        mv_cmplt = 1'b0;
        check("done_no_mv", 32'(cnt_mv), 32'd0);
        check("done_no_hd", 32'(cnt_hd), 32'd0);
        check("done_hold", 32'(outs()), 32'h03FF);
        cmd_md = 1'b0;
        tick();                                   // back to IDLE
        sol_cmplt = 1'b0;
        cmd_md = 1'b1;
        tick();                                   // IDLE -> MOVE proves IDLE reached
        check("restart_from_idle", 32'(outs()), 32'h23FF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/maze_solve.md
MAZE_SOLVE -- requirements
Module: maze_solve

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk (input, 1 bit, 50MHz system clock) and rst_n (input, 1 bit, asynchronous active-low reset).
REQ-002 cmd_md  input  1  solve enable; 1 = solving active, 0 = abort and return to IDLE.
REQ-003 cmd0  input  1  wall affinity, latched at solve start; 1 = left-wall follower, 0 = right-wall follower.
REQ-004 lft_opn  input  1  IR sensor indicates an opening to the left.
REQ-005 rght_opn  input  1  IR sensor indicates an opening to the right.
REQ-006 mv_cmplt  input  1  single-cycle pulse from navigate; heading change or forward move finished.
REQ-007 sol_cmplt  input  1  level input; magnet (maze exit) detected.
REQ-008 strt_hdng  output  1  single-cycle pulse; navigate starts a heading change.
REQ-009 strt_mv  output  1  single-cycle pulse; navigate starts a forward move.
REQ-010 stp_lft  output  1  level output; stop the move at the first left opening.
REQ-011 stp_rght  output  1  level output; stop the move at the first right opening.
REQ-012 dsrd_hdng  output  12  desired heading; signed, 4096 counts per revolution.

Function
REQ-013 The heading encodings SHALL be N=12'h000, W=12'h3FF, S=12'h7FF, E=12'hC00.
REQ-014 A left turn SHALL map N->W->S->E->N.
REQ-015 A right turn SHALL map N->E->S->W->N.
REQ-016 A reversal SHALL map N<->S and E<->W.
REQ-017 The FSM SHALL have the states IDLE, MOVE, WAIT_MV, DECIDE, HDNG, WAIT_HDNG, DONE.
REQ-018 IDLE: when cmd_md=1 is sampled, the block SHALL latch cmd0 into aff and go to MOVE.
REQ-019 MOVE: the block SHALL assert strt_mv for exactly one cycle, then go to WAIT_MV.
REQ-020 WAIT_MV: the block SHALL wait for mv_cmplt; if sol_cmplt=1 in the mv_cmplt cycle it SHALL go to DONE, else to DECIDE.
REQ-021 DECIDE with aff=1 SHALL apply: lft_opn -> left turn; else rght_opn -> right turn; else reversal.
REQ-022 DECIDE with aff=0 SHALL apply: rght_opn -> right turn; else lft_opn -> left turn; else reversal.
REQ-023 DECIDE SHALL register the new heading into dsrd_hdng and go to HDNG; DECIDE lasts one cycle.
REQ-024 HDNG: the block SHALL assert strt_hdng for exactly one cycle with dsrd_hdng already holding the new value, then go to WAIT_HDNG.
REQ-025 WAIT_HDNG: on mv_cmplt the block SHALL go to MOVE if sol_cmplt=0, else to DONE.
REQ-026 DONE: all pulses SHALL be 0 and dsrd_hdng held; the block SHALL return to IDLE when cmd_md=0.
REQ-027 stp_lft SHALL equal aff and stp_rght SHALL equal ~aff while the state is not IDLE or DONE; both SHALL be 0 in IDLE and DONE.
REQ-028 cmd_md=0 in any state SHALL force IDLE on the next clock, drop strt pulses to 0 and hold dsrd_hdng.
REQ-029 mv_cmplt SHALL be ignored outside WAIT_MV and WAIT_HDNG, including in the same cycle as strt_mv or strt_hdng.
REQ-030 strt_mv and strt_hdng SHALL never be high in the same cycle.
REQ-031 Each move or heading SHALL produce exactly one strt pulse per command.
REQ-032 All outputs SHALL be registered (glitch-free).
REQ-033 Turn latency SHALL be: mv_cmplt sampled at edge k -> DECIDE at k+1 -> strt_hdng high in the cycle after edge k+2.
REQ-034 Heading arithmetic SHALL use a table lookup, not addition; an out-of-table dsrd_hdng value SHALL map to N.

Reset
REQ-035 Asserting rst_n=0 SHALL asynchronously force: state=IDLE, aff=0, dsrd_hdng=12'h000, strt_hdng=0, strt_mv=0, stp_lft=0, stp_rght=0.
REQ-036 Reset mid-move SHALL discard all pending commands; after release the block SHALL wait for cmd_md=1.

Verification
REQ-037 Reset, cmd_md=1, cmd0=1 -> one strt_mv pulse 2 cycles later; stp_lft=1, stp_rght=0, dsrd_hdng=000.
REQ-038 aff=1, heading N, mv_cmplt with lft_opn=1, rght_opn=1 -> dsrd_hdng=3FF and one strt_hdng pulse; after the next mv_cmplt -> one strt_mv pulse.
REQ-039 aff=0, heading E, mv_cmplt with lft_opn=0, rght_opn=0 -> dsrd_hdng=3FF (reversal to W).
REQ-040 sol_cmplt=1 coincident with mv_cmplt in WAIT_MV -> DONE, no further strt pulses over 100 cycles; cmd_md=0 -> IDLE.
REQ-041 cmd_md dropped in WAIT_HDNG with mv_cmplt pulsed afterwards -> no strt pulses, stp_lft=stp_rght=0, dsrd_hdng held.
REQ-042 Spurious mv_cmplt in IDLE or DONE, and rst_n pulsed in WAIT_MV -> no outputs change except the reset values of REQ-035.
